// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial WIDTH-bit adder; define OVERFLOW_DETECT_EN to enable signed-overflow output
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0] count;
  logic carry, s, carry_nx, accept, last;
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  // one-bit add cell and FSM next-state; a start in DONE is accepted like one in IDLE
  always_comb begin
    s = a_sr[0] ^ b_sr[0] ^ carry;
    carry_nx = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    accept = start && state != S_RUN;
    last = state == S_RUN && count == LAST;
    state_nx = accept ? S_RUN : last ? S_DONE : state == S_DONE ? S_IDLE : state;
  end
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  // operand capture, serial shifting and result hand-off on the final bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      res <= '0;
      carry <= 1'b0;
      count <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      carry <= cin;
      count <= '0;
    end else if (state == S_RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      res <= {s, res[WIDTH-1:1]};
      carry <= carry_nx;
      count <= count + 1'b1;
      if (last) begin
        sum <= {s, res[WIDTH-1:1]};
        cout <= carry_nx;
      end
    end
  end
`ifdef OVERFLOW_DETECT_EN
  // on the MSB bit-cycle the carry flop holds the carry into the MSB
  always_ff @(posedge clk)
    if (!rst_n) ovf <= 1'b0;
    else if (last) ovf <= carry ^ carry_nx;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder
module tb_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, cout, ovf;
  logic [7:0] sum;
  int tests = 0, fails = 0;
`ifdef OVERFLOW_DETECT_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                       output int lat, output int bcnt, output logic [7:0] mid);
    a = oa; b = ob; cin = oc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0; bcnt = busy ? 1 : 0; mid = sum;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
      if (lat == 4) mid = sum;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done: got %b want 0", done); end
    tests++; if ({cout, sum} !== 9'h000) begin fails++; $display("FAIL reset sum: got %b/%h want 0/00", cout, sum); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat, bc; logic [7:0] mid;
    do_op(8'h5A, 8'h3C, 1'b0, lat, bc, mid);
    tests++; if (lat !== 8) begin fails++; $display("FAIL basic latency: got %0d want 8", lat); end
    tests++; if (bc !== 8) begin fails++; $display("FAIL basic busy cycles: got %0d want 8", bc); end
    tests++; if (mid !== 8'h00) begin fails++; $display("FAIL basic sum held mid-run: got %h want 00", mid); end
    tests++; if ({cout, sum} !== 9'h096) begin fails++; $display("FAIL basic 5A+3C: got %b/%h want 0/96", cout, sum); end
    tests++; if (ovf !== OV) begin fails++; $display("FAIL basic ovf: got %b want %b", ovf, OV); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic done width: got %b want 0", done); end
    tests++; if (sum !== 8'h96) begin fails++; $display("FAIL basic sum hold: got %h want 96", sum); end
  endtask

  task automatic test_carry;
    int lat, bc; logic [7:0] mid;
    do_op(8'hFF, 8'h01, 1'b0, lat, bc, mid);
    tests++; if ({cout, sum} !== 9'h100) begin fails++; $display("FAIL carry FF+01: got %b/%h want 1/00", cout, sum); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL carry FF+01 ovf: got %b want 0", ovf); end
    do_op(8'hFF, 8'h00, 1'b1, lat, bc, mid);
    tests++; if ({cout, sum} !== 9'h100) begin fails++; $display("FAIL carry FF+00+1: got %b/%h want 1/00", cout, sum); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL carry FF+00+1 ovf: got %b want 0", ovf); end
  endtask

  task automatic test_overflow;
    int lat, bc; logic [7:0] mid;
    do_op(8'h7F, 8'h01, 1'b0, lat, bc, mid);
    tests++; if (mid !== 8'h00) begin fails++; $display("FAIL ovf sum held mid-run: got %h want 00", mid); end
    tests++; if ({cout, sum} !== 9'h080) begin fails++; $display("FAIL ovf 7F+01: got %b/%h want 0/80", cout, sum); end
    tests++; if (ovf !== OV) begin fails++; $display("FAIL ovf 7F+01 ovf: got %b want %b", ovf, OV); end
  endtask

  task automatic test_ignore_start;
    int nd = 0; logic [7:0] s = 8'hxx;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) begin nd++; s = sum; end
    end
    tests++; if (nd !== 1) begin fails++; $display("FAIL ignore done pulses: got %0d want 1", nd); end
    tests++; if (s !== 8'h30) begin fails++; $display("FAIL ignore result: got %h want 30", s); end
    tests++; if ({cout, sum} !== 9'h030) begin fails++; $display("FAIL ignore held: got %b/%h want 0/30", cout, sum); end
  endtask

  task automatic test_reset_mid;
    int lat, bc; logic [7:0] mid;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL midreset busy/done: got %b%b want 00", busy, done); end
    tests++; if ({cout, sum, ovf} !== 10'h000) begin fails++; $display("FAIL midreset result: got %b/%h/%b want 0/00/0", cout, sum, ovf); end
    do_op(8'h01, 8'h02, 1'b0, lat, bc, mid);
    tests++; if (lat !== 8) begin fails++; $display("FAIL midreset latency: got %0d want 8", lat); end
    tests++; if ({cout, sum} !== 9'h003) begin fails++; $display("FAIL midreset 01+02: got %b/%h want 0/03", cout, sum); end
  endtask

  task automatic test_back_to_back;
    int nd = 0, last_c = 0;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (nd == 0) begin
          tests++; if (c !== 8) begin fails++; $display("FAIL b2b first done: got edge %0d want 8", c); end
        end else begin
          tests++; if (c - last_c !== 9) begin fails++; $display("FAIL b2b period: got %0d want 9", c - last_c); end
        end
        tests++; if ({cout, sum} !== 9'h002) begin fails++; $display("FAIL b2b 01+01: got %b/%h want 0/02", cout, sum); end
        nd++; last_c = c;
      end
    end
    start = 1'b0;
    tests++; if (nd !== 4) begin fails++; $display("FAIL b2b done count: got %0d want 4", nd); end
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around a single one-bit add cell: sum = x ^ y ^ carry, carry = majority(x, y, carry). The cell is fed LSB-first from operand shift registers, with the carry held in a flip-flop between bits. It sits between a requester, which supplies operands with a start pulse, and the consumer of sum/cout. It trades latency for area against the combinational half/full-adder blocks.

Parameters:
WIDTH, 8, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  request; sampled only when not busy
a  input  WIDTH  operand A, captured when start is accepted
b  input  WIDTH  operand B, captured when start is accepted
cin  input  1  carry-in, captured when start is accepted
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse; sum/cout valid from this cycle
sum  output  WIDTH  result, held until the next accepted start
cout  output  1  carry-out, held with sum
ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (rst_n low at a rising clk edge):
  - State goes to IDLE.
  - busy, done, sum, cout, ovf, carry flop and bit counter all go to 0.
  - Reset has priority over every other event, including mid-RUN; the partial result is discarded.
- FSM states:
  - IDLE: waiting for start.
  - RUN: processing one bit per cycle.
  - DONE: single cycle with done=1.
- IDLE -> RUN, on start=1:
  - Load a_sr<=a, b_sr<=b, carry<=cin, count<=0.
  - busy<=1.
  - sum and cout keep their previous values until DONE.
- RUN, each cycle:
  - Compute s = a_sr[0]^b_sr[0]^carry.
  - Shift a_sr and b_sr right by one.
  - Shift s into the result register from the MSB side.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - count <= count+1.
- RUN -> DONE after exactly WIDTH bit-cycles, i.e. when count == WIDTH-1 is processed:
  - Transfer the result register to sum and the final carry to cout.
  - busy<=0, done<=1.
- DONE -> IDLE unconditionally next cycle; done returns to 0.
  - A start seen in the DONE cycle is accepted exactly as in IDLE (back-to-back operation).
- Latency: start accepted at edge k; busy=1 after edges k .. k+WIDTH-1; done=1 for the single cycle following edge k+WIDTH.
  - WIDTH=8 gives done 8 clocks after the start edge, and one addition every WIDTH+1 cycles.
- start while busy=1 is ignored. It has no effect on the operands, the count or the result.
- a, b and cin are don't-care except at the accept edge; changing them mid-RUN has no effect.
- Arithmetic is unsigned modulo 2^WIDTH:
  - {cout,sum} = a + b + cin.
  - Counter width is clog2(WIDTH), wrapping is not relied on.

Optional Feature:
Macro OVERFLOW_DETECT_EN.
- Defined:
  - Latch the carry into the MSB bit-cycle.
  - At DONE, ovf <= carry_into_msb ^ final carry (two's-complement overflow).
  - ovf is held with sum and cleared by reset.
- Undefined:
  - The ovf port stays present but is tied to 0.
  - No extra flops are inferred.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start -> busy high 8 cycles, done pulse 8 clocks after the start edge, sum=0x96, cout=0, ovf=1 (macro on).
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Macro on: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1; macro off: same stimulus -> ovf=0.
- Start accepted with a=0x10, b=0x20; at cycle 3 pulse start with a=0xAA, b=0x55 -> ignored; result sum=0x30, exactly one done pulse.
- rst_n low for one cycle at bit-cycle 4 of 0x12+0x34 -> busy=0, done=0, sum=0, cout=0 next cycle; new start of 0x01+0x02 -> sum=0x03.
- Start held high continuously with a=0x01, b=0x01 -> results every 9 cycles, done one cycle wide each time, sum=0x02.
